// File: rtl/vscale_hpm_counter_file_pkg.sv
// Shared definitions for the HPM counter bank: CSR command and privilege
// encodings, the HPM address map, and the address decoder used by the top.
package vscale_hpm_counter_file_pkg;

    // CSR command encodings shared with the core CSR file
    localparam logic [2:0] CSR_IDLE  = 3'b000;
    localparam logic [2:0] CSR_READ  = 3'b100;
    localparam logic [2:0] CSR_WRITE = 3'b101;
    localparam logic [2:0] CSR_SET   = 3'b110;
    localparam logic [2:0] CSR_CLEAR = 3'b111;

    // Privilege levels
    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_S = 2'd1;
    localparam logic [1:0] PRV_H = 2'd2;
    localparam logic [1:0] PRV_M = 2'd3;

    // HPM address map; per-counter registers are base + counter index
    localparam logic [11:0] CSR_ADDR_MHPMCNT_LO_BASE = 12'hB03;
    localparam logic [11:0] CSR_ADDR_MHPMCNT_HI_BASE = 12'hB83;
    localparam logic [11:0] CSR_ADDR_HPMCNT_LO_BASE  = 12'hC03;
    localparam logic [11:0] CSR_ADDR_HPMCNT_HI_BASE  = 12'hC83;
    localparam logic [11:0] CSR_ADDR_HPMSEL_BASE     = 12'h323;
    localparam logic [11:0] CSR_ADDR_HPMINHIBIT      = 12'h320;
    localparam logic [11:0] CSR_ADDR_HPMOVF          = 12'h7C0;
    localparam logic [11:0] CSR_ADDR_HPMOVFEN        = 12'h7C1;

    // Low half of every counter is one 32-bit CSR
    localparam int CSR_LO_W = 32;

    // The map has room for at most 29 counters; index fits in 5 bits
    localparam int HPM_MAX_COUNTERS = 29;
    localparam int HPM_IDX_W        = 5;

    // Which HPM register an address selects
    typedef enum logic [2:0] {
        REG_NONE,
        REG_CNT_LO,
        REG_CNT_HI,
        REG_SEL,
        REG_INHIBIT,
        REG_OVF,
        REG_OVFEN
    } hpm_reg_t;

    typedef struct packed {
        logic                 claimed;
        hpm_reg_t             kind;
        logic [HPM_IDX_W-1:0] index;
    } hpm_decode_t;

    // Event selector width: one code per event plus one "select nothing" code
    function automatic int sel_w(input int n_events);
        return $clog2(n_events + 1);
    endfunction

    // Map a CSR address onto an HPM register; machine and user views of a
    // counter half decode to the same register (privilege is checked apart).
    function automatic hpm_decode_t hpm_decode(input logic [11:0] addr,
                                               input int          n_counters);
        hpm_decode_t d;
        d.claimed = 1'b0;
        d.kind    = REG_NONE;
        d.index   = '0;
        if (addr == CSR_ADDR_HPMINHIBIT) begin
            d.claimed = 1'b1;
            d.kind    = REG_INHIBIT;
        end else if (addr == CSR_ADDR_HPMOVF) begin
            d.claimed = 1'b1;
            d.kind    = REG_OVF;
        end else if (addr == CSR_ADDR_HPMOVFEN) begin
            d.claimed = 1'b1;
            d.kind    = REG_OVFEN;
        end
        for (int i = 0; i < HPM_MAX_COUNTERS; i++) begin
            if (i < n_counters) begin
                if (addr == CSR_ADDR_MHPMCNT_LO_BASE + 12'(i) ||
                    addr == CSR_ADDR_HPMCNT_LO_BASE + 12'(i)) begin
                    d.claimed = 1'b1;
                    d.kind    = REG_CNT_LO;
                    d.index   = HPM_IDX_W'(i);
                end
                if (addr == CSR_ADDR_MHPMCNT_HI_BASE + 12'(i) ||
                    addr == CSR_ADDR_HPMCNT_HI_BASE + 12'(i)) begin
                    d.claimed = 1'b1;
                    d.kind    = REG_CNT_HI;
                    d.index   = HPM_IDX_W'(i);
                end
                if (addr == CSR_ADDR_HPMSEL_BASE + 12'(i)) begin
                    d.claimed = 1'b1;
                    d.kind    = REG_SEL;
                    d.index   = HPM_IDX_W'(i);
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/vscale_hpm_counter.sv
// One HPM counter: event selector, increment qualification, wrap detection
// and independent software write ports for the low and high halves.
module vscale_hpm_counter
    import vscale_hpm_counter_file_pkg::*;
#(
    parameter int COUNTER_WIDTH = 64,
    parameter int N_EVENTS      = 8,
    parameter int SEL_W         = sel_w(N_EVENTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_EVENTS-1:0]           events,
    input  logic                          inhibit,
    input  logic                          freeze,
    input  logic                          sel_we,
    input  logic [SEL_W-1:0]              sel_wdata,
    input  logic                          lo_we,
    input  logic [CSR_LO_W-1:0]           lo_wdata,
    input  logic                          hi_we,
    input  logic [COUNTER_WIDTH-CSR_LO_W-1:0] hi_wdata,
    output logic [COUNTER_WIDTH-1:0]      count,
    output logic [SEL_W-1:0]              sel,
    output logic                          ovf_pulse
);

    localparam int EXT_W = 2 ** SEL_W;

    // Events padded so every selector code indexes a real bit; padding is 0
    logic [EXT_W-1:0] events_ext;
    logic             sel_valid;
    logic             inc;
    logic             sw_write;

    assign events_ext = {{(EXT_W - N_EVENTS){1'b0}}, events};
    assign sel_valid  = sel < SEL_W'(N_EVENTS);
    assign inc        = sel_valid && events_ext[sel] && !inhibit && !freeze;
    assign sw_write   = lo_we || hi_we;

    // Overflow is flagged only when the increment really happens and wraps
    assign ovf_pulse  = inc && (&count) && !sw_write;

    // Counter: a software write to either half beats the increment
    // NOTE: clocked state uses non-blocking assignments so every flop sees pre-edge values.
    // NOTE: all state here is plain flops (no RAM), so everything sits on the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (lo_we) begin
            count[CSR_LO_W-1:0] <= lo_wdata;
        end else if (hi_we) begin
            count[COUNTER_WIDTH-1:CSR_LO_W] <= hi_wdata;
        end else if (inc) begin
            count <= count + COUNTER_WIDTH'(1);
        end
    end

    // Event selector; resets to the "select nothing" code
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel <= SEL_W'(N_EVENTS);
        end else if (sel_we) begin
            sel <= sel_wdata;
        end
    end

endmodule

// File: rtl/vscale_hpm_counter_file.sv
// HPM CSR bank: N_COUNTERS event counters with per-counter inhibit, sticky
// overflow bits and a maskable, registered overflow interrupt. Shares the
// CSR port with the core CSR file; unclaimed addresses read 0, never illegal.
module vscale_hpm_counter_file
    import vscale_hpm_counter_file_pkg::*;
#(
    parameter int N_COUNTERS    = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int N_EVENTS      = 8,
    parameter int XPR_LEN       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [11:0]         addr,
    input  logic [2:0]          cmd,
    input  logic [XPR_LEN-1:0]  wdata,
    input  logic [1:0]          prv,
    input  logic [N_EVENTS-1:0] events,
    input  logic                freeze,
    output logic [XPR_LEN-1:0]  rdata,
    output logic                illegal_access,
    output logic                overflow_irq
);

    localparam int SEL_W = sel_w(N_EVENTS);
    localparam int HI_W  = COUNTER_WIDTH - CSR_LO_W;

    hpm_decode_t dec;

    logic is_access;
    logic is_write;
    logic privilege_fault;
    logic readonly_fault;
    logic wr_en;

    logic [COUNTER_WIDTH-1:0] count [N_COUNTERS];
    logic [SEL_W-1:0]         sel   [N_COUNTERS];

    logic [COUNTER_WIDTH-1:0] cnt_mux;
    logic [SEL_W-1:0]         sel_mux;
    logic [XPR_LEN-1:0]       read_val;
    logic [XPR_LEN-1:0]       wval;

    logic [N_COUNTERS-1:0] lo_we;
    logic [N_COUNTERS-1:0] hi_we;
    logic [N_COUNTERS-1:0] sel_we;
    logic [N_COUNTERS-1:0] ovf_set;

    logic [N_COUNTERS-1:0] inhibit;
    logic [N_COUNTERS-1:0] ovf;
    logic [N_COUNTERS-1:0] ovfen;

    assign dec = hpm_decode(addr, N_COUNTERS);

    // Access checks: address bits [9:8] give the minimum privilege and
    // [11:10] == 2'b11 marks the read-only space
    assign is_access       = cmd[2];
    assign is_write        = cmd[1] | cmd[0];
    assign privilege_fault = addr[9:8] > prv;
    assign readonly_fault  = is_write && (addr[11:10] == 2'b11);
    assign illegal_access  = is_access && dec.claimed && (privilege_fault || readonly_fault);
    assign wr_en           = is_access && is_write && dec.claimed && !illegal_access;

    // Pick the addressed counter and selector out of the bank
    // NOTE: every variable of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        cnt_mux = '0;
        sel_mux = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (dec.index == HPM_IDX_W'(i)) begin
                cnt_mux = count[i];
                sel_mux = sel[i];
            end
        end
    end

    // Read data, zero-extended; REG_NONE (unclaimed) reads 0
    always_comb begin
        read_val = '0;
        case (dec.kind)
            REG_CNT_LO:  read_val = XPR_LEN'(cnt_mux[CSR_LO_W-1:0]);
            REG_CNT_HI:  read_val = XPR_LEN'(cnt_mux[COUNTER_WIDTH-1:CSR_LO_W]);
            REG_SEL:     read_val = XPR_LEN'(sel_mux);
            REG_INHIBIT: read_val = XPR_LEN'(inhibit);
            REG_OVF:     read_val = XPR_LEN'(ovf);
            REG_OVFEN:   read_val = XPR_LEN'(ovfen);
            default:     read_val = '0;
        endcase
    end

    assign rdata = read_val;

    // Value to store for the read-modify-write commands
    always_comb begin
        wval = wdata;
        case (cmd)
            CSR_SET:   wval = read_val | wdata;
            CSR_CLEAR: wval = read_val & ~wdata;
            default:   wval = wdata;
        endcase
    end

    // Per-counter write strobes for the addressed counter
    always_comb begin
        lo_we  = '0;
        hi_we  = '0;
        sel_we = '0;
        for (int i = 0; i < N_COUNTERS; i++) begin
            if (dec.index == HPM_IDX_W'(i)) begin
                lo_we[i]  = wr_en && (dec.kind == REG_CNT_LO);
                hi_we[i]  = wr_en && (dec.kind == REG_CNT_HI);
                sel_we[i] = wr_en && (dec.kind == REG_SEL);
            end
        end
    end

    for (genvar g = 0; g < N_COUNTERS; g++) begin : g_counter
        vscale_hpm_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .N_EVENTS      (N_EVENTS),
            .SEL_W         (SEL_W)
        ) u_counter (
            .clk       (clk),
            .reset     (reset),
            .events    (events),
            .inhibit   (inhibit[g]),
            .freeze    (freeze),
            .sel_we    (sel_we[g]),
            .sel_wdata (wval[SEL_W-1:0]),
            .lo_we     (lo_we[g]),
            .lo_wdata  (wval[CSR_LO_W-1:0]),
            .hi_we     (hi_we[g]),
            .hi_wdata  (wval[HI_W-1:0]),
            .count     (count[g]),
            .sel       (sel[g]),
            .ovf_pulse (ovf_set[g])
        );
    end

    // Bank control registers; hardware overflow sets are ORed over a software write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inhibit <= '0;
            ovfen   <= '0;
            ovf     <= '0;
        end else begin
            if (wr_en && dec.kind == REG_INHIBIT) begin
                inhibit <= wval[N_COUNTERS-1:0];
            end
            if (wr_en && dec.kind == REG_OVFEN) begin
                ovfen <= wval[N_COUNTERS-1:0];
            end
            if (wr_en && dec.kind == REG_OVF) begin
                ovf <= wval[N_COUNTERS-1:0] | ovf_set;
            end else begin
                ovf <= ovf | ovf_set;
            end
        end
    end

    // Interrupt follows the visible overflow/enable state one cycle later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_irq <= 1'b0;
        end else begin
            overflow_irq <= |(ovf & ovfen);
        end
    end

endmodule

// File: tb/tb_vscale_hpm_counter_file.sv
// Bench for the HPM counter bank: directed scenarios followed by random CSR
// traffic, all checked against a per-cycle behavioural model.
module tb_vscale_hpm_counter_file;
    import vscale_hpm_counter_file_pkg::*;

    localparam int N = 4;
    localparam int E = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] addr;
    logic [2:0]  cmd;
    logic [31:0] wdata;
    logic [1:0]  prv;
    logic [7:0]  events;
    logic        freeze;
    logic [31:0] rdata;
    logic        illegal_access;
    logic        overflow_irq;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [63:0] m_cnt [N];
    logic [3:0]  m_sel [N];
    logic [3:0]  m_inh;
    logic [3:0]  m_ovf;
    logic [3:0]  m_ovfen;
    logic        m_irq;

    logic [31:0] last_rdata;
    logic        last_ill;
    logic        last_irq;

    vscale_hpm_counter_file dut (
        .clk            (clk),
        .reset          (reset),
        .addr           (addr),
        .cmd            (cmd),
        .wdata          (wdata),
        .prv            (prv),
        .events         (events),
        .freeze         (freeze),
        .rdata          (rdata),
        .illegal_access (illegal_access),
        .overflow_irq   (overflow_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = 4'(E);
        end
        m_inh   = '0;
        m_ovf   = '0;
        m_ovfen = '0;
        m_irq   = 1'b0;
    endtask

    // What a CSR access would see, straight from the address table
    task automatic model_read(input logic [11:0] a, input logic [1:0] p, input logic [2:0] c,
                              output bit claimed, output logic [31:0] val, output bit ill);
        int ia;
        ia      = int'(a);
        claimed = 0;
        val     = '0;
        for (int i = 0; i < N; i++) begin
            if (ia == 'hB03 + i || ia == 'hC03 + i) begin
                claimed = 1;
                val     = m_cnt[i][31:0];
            end
            if (ia == 'hB83 + i || ia == 'hC83 + i) begin
                claimed = 1;
                val     = m_cnt[i][63:32];
            end
            if (ia == 'h323 + i) begin
                claimed = 1;
                val     = {28'd0, m_sel[i]};
            end
        end
        if (ia == 'h320) begin claimed = 1; val = {28'd0, m_inh};   end
        if (ia == 'h7C0) begin claimed = 1; val = {28'd0, m_ovf};   end
        if (ia == 'h7C1) begin claimed = 1; val = {28'd0, m_ovfen}; end
        ill = c[2] && claimed && ((a[9:8] > p) || ((c[1] | c[0]) && a[11:10] == 2'b11));
    endtask

    // One clock of the model: counting, writes, overflow and interrupt
    task automatic model_clock(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d,
                               input logic [31:0] val, input bit claimed, input bit ill);
        bit          dw;
        bit          inc;
        logic [31:0] wv;
        logic [3:0]  sets;
        logic [3:0]  new_sel [N];
        logic        new_irq;
        int          ia;
        ia      = int'(a);
        sets    = '0;
        new_irq = |(m_ovf & m_ovfen);
        dw      = c[2] && (c[1] | c[0]) && claimed && !ill;
        if (c == CSR_SET)        wv = val | d;
        else if (c == CSR_CLEAR) wv = val & ~d;
        else                     wv = d;
        for (int i = 0; i < N; i++) begin
            inc = 0;
            if (m_sel[i] < 4'(E)) inc = events[m_sel[i][2:0]] && !m_inh[i] && !freeze;
            new_sel[i] = m_sel[i];
            if (dw && ia == 'hB03 + i) begin
                m_cnt[i][31:0] = wv;
            end else if (dw && ia == 'hB83 + i) begin
                m_cnt[i][63:32] = wv;
            end else if (inc) begin
                if (m_cnt[i] == 64'hFFFF_FFFF_FFFF_FFFF) sets[i] = 1'b1;
                m_cnt[i] = m_cnt[i] + 64'd1;
            end
            if (dw && ia == 'h323 + i) new_sel[i] = wv[3:0];
        end
        for (int i = 0; i < N; i++) m_sel[i] = new_sel[i];
        if (dw && ia == 'h320) m_inh = wv[3:0];
        if (dw && ia == 'h7C1) m_ovfen = wv[3:0];
        if (dw && ia == 'h7C0) m_ovf = wv[3:0] | sets;
        else                   m_ovf = m_ovf | sets;
        m_irq = new_irq;
    endtask

    // Drive one CSR cycle (entered just after a falling edge)
    task automatic step(input logic [2:0] c, input logic [11:0] a, input logic [31:0] d);
        bit          cl;
        bit          ill;
        logic [31:0] val;
        cmd   = c;
        addr  = a;
        wdata = d;
        #1;
        model_read(a, prv, c, cl, val, ill);
        check($sformatf("rdata@%h", a), rdata, val);
        check($sformatf("illegal@%h", a), illegal_access, ill);
        last_rdata = rdata;
        last_ill   = illegal_access;
        model_clock(c, a, d, val, cl, ill);
        @(posedge clk);
        #1;
        check("irq", overflow_irq, m_irq);
        last_irq = overflow_irq;
        cmd = CSR_IDLE;
        @(negedge clk);
    endtask

    logic [11:0] addr_pool [28] = '{
        12'hB03, 12'hB04, 12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86,
        12'hC03, 12'hC04, 12'hC05, 12'hC06, 12'hC83, 12'hC84, 12'hC85, 12'hC86,
        12'h323, 12'h324, 12'h325, 12'h326, 12'h320, 12'h7C0, 12'h7C1,
        12'hB07, 12'hC87, 12'h327, 12'h7C2, 12'h000
    };
    logic [2:0] cmd_pool [5] = '{CSR_IDLE, CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR};

    initial begin
        reset  = 1'b0;
        cmd    = CSR_IDLE;
        addr   = '0;
        wdata  = '0;
        prv    = PRV_M;
        events = '0;
        freeze = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        addr = 12'hC03;
        cmd  = CSR_READ;
        #1;
        check("in_reset_rdata", rdata, 0);
        check("in_reset_irq", overflow_irq, 0);
        @(negedge clk);
        reset = 1'b1;
        cmd   = CSR_IDLE;

        // Reset state
        step(CSR_READ, 12'h323, 0);
        check("reset_sel0", last_rdata, E);
        step(CSR_READ, 12'h7C0, 0);
        check("reset_ovf", last_rdata, 0);

        // 1: counter0 follows event 2 only
        step(CSR_WRITE, 12'h323, 2);
        events = 8'b0000_0110;
        for (int k = 0; k < 5; k++) step(CSR_IDLE, 12'h000, 0);
        events = 8'h00;
        step(CSR_READ, 12'hC03, 0);
        check("t1_lo0", last_rdata, 5);
        step(CSR_READ, 12'hC83, 0);
        check("t1_hi0", last_rdata, 0);
        step(CSR_READ, 12'hC04, 0);
        check("t1_lo1", last_rdata, 0);

        // 2: wrap, overflow and interrupt timing
        step(CSR_WRITE, 12'hB83, 32'hFFFF_FFFF);
        step(CSR_WRITE, 12'hB03, 32'hFFFF_FFFE);
        step(CSR_WRITE, 12'h323, 0);
        step(CSR_WRITE, 12'h7C1, 1);
        events = 8'h01;
        step(CSR_IDLE, 12'h000, 0);
        step(CSR_IDLE, 12'h000, 0);
        events = 8'h00;
        check("t2_irq_not_yet", last_irq, 0);
        step(CSR_READ, 12'h7C0, 0);
        check("t2_ovf0", last_rdata, 1);
        check("t2_irq_rise", last_irq, 1);
        step(CSR_READ, 12'hB03, 0);
        check("t2_lo0_wrapped", last_rdata, 0);
        step(CSR_READ, 12'hB83, 0);
        check("t2_hi0_wrapped", last_rdata, 0);
        step(CSR_CLEAR, 12'h7C0, 1);
        check("t2_irq_hold", last_irq, 1);
        step(CSR_IDLE, 12'h000, 0);
        check("t2_irq_drop", last_irq, 0);

        // 3: software write beats a same-cycle event
        events = 8'h01;
        step(CSR_WRITE, 12'hB03, 100);
        step(CSR_READ, 12'hB03, 0);
        check("t3_write_wins", last_rdata, 100);
        events = 8'h00;
        step(CSR_READ, 12'hB03, 0);
        check("t3_next_event", last_rdata, 101);

        // 4: privilege and read-only checks
        step(CSR_WRITE, 12'hB04, 32'h1234);
        prv = PRV_U;
        step(CSR_READ, 12'hC04, 0);
        check("t4_user_read", last_rdata, 32'h1234);
        check("t4_user_legal", last_ill, 0);
        step(CSR_READ, 12'hB04, 0);
        check("t4_user_mread", last_ill, 1);
        step(CSR_READ, 12'hB07, 0);
        check("t4_unclaimed_ill", last_ill, 0);
        check("t4_unclaimed_data", last_rdata, 0);
        prv = PRV_M;
        step(CSR_WRITE, 12'hC04, 32'hDEAD);
        check("t4_ro_write", last_ill, 1);
        step(CSR_READ, 12'hB04, 0);
        check("t4_ro_unchanged", last_rdata, 32'h1234);

        // 5: inhibit and freeze
        step(CSR_WRITE, 12'h320, 32'b0010);
        step(CSR_WRITE, 12'h324, 0);
        events = 8'h01;
        foreach (addr_pool[k]) begin
            if (k < 7) begin
                freeze = (k == 1 || k == 2 || k == 5);
                step(CSR_IDLE, 12'h000, 0);
            end
        end
        events = 8'h00;
        freeze = 1'b0;
        step(CSR_READ, 12'hB03, 0);
        check("t5_cnt0", last_rdata, 105);
        step(CSR_READ, 12'hB04, 0);
        check("t5_cnt1_inhibited", last_rdata, 32'h1234);

        // 6: asynchronous reset mid-count
        step(CSR_WRITE, 12'h7C0, 1);
        step(CSR_IDLE, 12'h000, 0);
        check("t6_irq_before", last_irq, 1);
        events = 8'h01;
        for (int k = 0; k < 3; k++) step(CSR_IDLE, 12'h000, 0);
        cmd  = CSR_READ;
        addr = 12'hB03;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_cnt0_cleared", rdata, 0);
        check("t6_irq_cleared", overflow_irq, 0);
        addr = 12'h7C0;
        #1;
        check("t6_ovf_cleared", rdata, 0);
        addr = 12'hB04;
        #1;
        check("t6_cnt1_cleared", rdata, 0);
        model_reset();
        @(negedge clk);
        events = 8'h00;
        cmd    = CSR_IDLE;
        reset  = 1'b1;
        step(CSR_READ, 12'h324, 0);
        check("t6_sel1_reset", last_rdata, E);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            logic [31:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'hFFFF_FFFF - 32'($urandom_range(0, 6));
                1:       d = 32'($urandom_range(0, 9));
                default: d = $urandom;
            endcase
            events = 8'($urandom);
            freeze = ($urandom_range(0, 7) == 0);
            prv    = 2'($urandom_range(0, 3));
            step(cmd_pool[$urandom_range(0, 4)], addr_pool[$urandom_range(0, 27)], d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
